// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state codes, frame constants and strobe helper for the boot loader
package loader_pkg;

   typedef logic [2:0] loader_state_t;

   localparam loader_state_t ST_SYNC  = 3'd0;
   localparam loader_state_t ST_LEN   = 3'd1;
   localparam loader_state_t ST_DATA  = 3'd2;
   localparam loader_state_t ST_WRITE = 3'd3;
   localparam loader_state_t ST_CSUM  = 3'd4;
   localparam loader_state_t ST_NAK   = 3'd5;
   localparam loader_state_t ST_DONE  = 3'd6;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
   localparam logic [7:0] DEF_ACK_NAK   = 8'h15;

   // One-hot byte-lane enable for a lane index within a 32-bit word.
   function automatic logic [3:0] lane_strobe(input logic [1:0] lane);
      lane_strobe = 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/uart_byte_port.sv
// rtl/uart_byte_port.sv - turns read/write byte requests into the uart valid/ready/wmask handshake
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   rd_req, wr_req       level requests from the frame FSM (wr_req wins if both set)
//   wr_data              byte to transmit on a write request
//   uart_valid/ready     handshake with the uart peripheral
//   uart_wmask           1 = transmit, 0 = read
//   uart_wdata           transmit byte, held stable while valid
//   uart_rdata           received byte from the uart
//   byte_done            one-cycle pulse in the cycle a transfer completes
//   byte_data            received byte accompanying byte_done
module uart_byte_port
   import loader_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       rd_req,
   input  logic       wr_req,
   input  logic [7:0] wr_data,
   output logic       uart_valid,
   input  logic       uart_ready,
   output logic       uart_wmask,
   output logic [7:0] uart_wdata,
   input  logic [7:0] uart_rdata,
   output logic       byte_done,
   output logic [7:0] byte_data
);

   // Completion is reported combinationally so the FSM advances on the
   // completing edge itself; the data is only meaningful with byte_done.
   assign byte_done = uart_valid && uart_ready;
   assign byte_data = uart_rdata;

   // A new request is only launched from idle, so valid always drops for one
   // cycle after a completion and the FSM state has settled before reissue.
   always_ff @(posedge clk) begin
      if (reset) begin
         uart_valid <= 1'b0;
         uart_wmask <= 1'b0;
         uart_wdata <= 8'h00;
      end else if (uart_valid) begin
         if (uart_ready)
            uart_valid <= 1'b0;
      end else if (rd_req || wr_req) begin
         uart_valid <= 1'b1;
         uart_wmask <= wr_req;
         uart_wdata <= wr_req ? wr_data : 8'h00;
      end
   end

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - receives a framed image over the uart, writes it to memory, replies with a checksum
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   uart_valid/ready/wmask        byte interface towards the uart peripheral
//   uart_wdata/rdata              transmit / receive bytes
//   mem_valid/ready               memory write handshake
//   mem_addr/wdata/wstrb          word-aligned write, little-endian lanes
//   cpu_reset                     holds the CPU in reset until loading finishes
//   done                          image loaded and checksum sent
module uart_boot_loader
   import loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] MAX_LEN   = 32'h0001_0000,
   parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE,
   parameter logic [7:0]  ACK_NAK   = DEF_ACK_NAK
)
(
   input  logic        clk,
   input  logic        reset,
   output logic        uart_valid,
   input  logic        uart_ready,
   output logic        uart_wmask,
   output logic [7:0]  uart_wdata,
   input  logic [7:0]  uart_rdata,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   output logic        cpu_reset,
   output logic        done
);

   loader_state_t state;
   logic [31:0]   length;
   logic [31:0]   idx;
   logic [1:0]    len_cnt;
   logic [7:0]    csum;
   logic [31:0]   word_buf;
   logic [3:0]    word_strb;

   logic          rd_req;
   logic          wr_req;
   logic [7:0]    wr_data;
   logic          byte_done;
   logic [7:0]    byte_data;

   logic [31:0]   len_shift;
   logic [1:0]    lane;
   logic [31:0]   word_nx;
   logic [3:0]    strb_nx;
   logic          last_byte;

   always_comb begin
      rd_req  = (state == ST_SYNC) || (state == ST_LEN) || (state == ST_DATA);
      wr_req  = (state == ST_CSUM) || (state == ST_NAK);
      wr_data = (state == ST_CSUM) ? csum : ACK_NAK;
   end

   // Length arrives LSB first: shifting each byte in from the top leaves
   // byte 0 in bits [7:0] after the fourth byte.
   always_comb begin
      len_shift = {byte_data, length[31:8]};
      lane      = idx[1:0];
      word_nx   = word_buf | ({24'h0, byte_data} << {lane, 3'b000});
      strb_nx   = word_strb | lane_strobe(lane);
      last_byte = (idx == length - 32'd1);
   end

   uart_byte_port u_port (
      .clk        (clk),
      .reset      (reset),
      .rd_req     (rd_req),
      .wr_req     (wr_req),
      .wr_data    (wr_data),
      .uart_valid (uart_valid),
      .uart_ready (uart_ready),
      .uart_wmask (uart_wmask),
      .uart_wdata (uart_wdata),
      .uart_rdata (uart_rdata),
      .byte_done  (byte_done),
      .byte_data  (byte_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_SYNC;
         length    <= 32'h0;
         idx       <= 32'h0;
         len_cnt   <= 2'd0;
         csum      <= 8'h00;
         word_buf  <= 32'h0;
         word_strb <= 4'h0;
         mem_valid <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= 32'h0;
         mem_wstrb <= 4'h0;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
      end else begin
         case (state)
            ST_SYNC: begin
               if (byte_done && byte_data == SYNC_BYTE) begin
                  state     <= ST_LEN;
                  len_cnt   <= 2'd0;
                  length    <= 32'h0;
                  csum      <= 8'h00;
                  word_buf  <= 32'h0;
                  word_strb <= 4'h0;
               end
            end
            ST_LEN: begin
               if (byte_done) begin
                  length  <= len_shift;
                  len_cnt <= len_cnt + 2'd1;
                  if (len_cnt == 2'd3) begin
                     idx <= 32'h0;
                     if (len_shift > MAX_LEN)
                        state <= ST_NAK;
                     else if (len_shift == 32'h0)
                        state <= ST_CSUM;
                     else
                        state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (byte_done) begin
                  csum <= csum + byte_data;
                  if (lane == 2'd3 || last_byte) begin
                     state     <= ST_WRITE;
                     word_buf  <= word_nx;
                     word_strb <= strb_nx;
                     mem_valid <= 1'b1;
                     mem_addr  <= BASE_ADDR + {idx[31:2], 2'b00};
                     mem_wdata <= word_nx;
                     mem_wstrb <= strb_nx;
                  end else begin
                     word_buf  <= word_nx;
                     word_strb <= strb_nx;
                     idx       <= idx + 32'd1;
                  end
               end
            end
            ST_WRITE: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  word_buf  <= 32'h0;
                  word_strb <= 4'h0;
                  if (last_byte) begin
                     state <= ST_CSUM;
                  end else begin
                     idx   <= idx + 32'd1;
                     state <= ST_DATA;
                  end
               end
            end
            ST_CSUM: begin
               if (byte_done) begin
                  state     <= ST_DONE;
                  done      <= 1'b1;
                  cpu_reset <= 1'b0;
               end
            end
            ST_NAK: begin
               if (byte_done)
                  state <= ST_SYNC;
            end
            ST_DONE: begin
               done      <= 1'b1;
               cpu_reset <= 1'b0;
            end
            default: state <= ST_SYNC;
         endcase
      end
   end

endmodule
